countdown_ctrl: RTL and testbench
=================================

# countdown_ctrl

Sequencing controller for the four-digit seven-segment countdown timer. Holds the mm:ss countdown value in BCD, runs the set/run/pause/done state machine from debounced button pulses and a 1 Hz tick, and drives the `digit_3..digit_0` and `enable_3..enable_0` inputs of the `display` scan module. It also blinks the display and raises `alarm` when the count expires.

## Interface
- `ALARM_TICKS`, default 10: number of ticks spent in DONE before returning automatically to IDLE; 0 means stay in DONE until a button is pressed; 8-bit range.
- `clk`  in  1  system clock; the same clock that drives `display.scan_clk`.
- `rst`  in  1  reset, synchronous and active-high.
- `tick`  in  1  1 Hz enable pulse from the prescaler; one `clk` wide.
- `btn_start`  in  1  start/pause/acknowledge; one-cycle pulse, already debounced.
- `btn_set_min`  in  1  increment minutes in IDLE; one-cycle pulse.
- `btn_set_sec`  in  1  increment seconds in IDLE; one-cycle pulse.
- `btn_clear`  in  1  abort and zero; one-cycle pulse.
- `digit_3` / `digit_2`  out  4  minutes tens/ones, BCD.
- `digit_1` / `digit_0`  out  4  seconds tens/ones, BCD.
- `enable_3..enable_0`  out  1 each  digit enables to `display`; 1 = lit.
- `alarm`  out  1  high throughout DONE.

## Operation
- **Registers**
  - `cur`: current mm:ss, BCD. Minutes run 00–99 and seconds 00–59.
  - `preset`: the value captured at start.
  - FSM: IDLE, RUN, PAUSE, DONE.
  - `blink`: 1 bit.
  - `acnt`: 8-bit count of ticks spent in DONE.
  - Digit outputs equal `cur` directly.
- **IDLE**
  - `btn_set_min`: minutes +1, wrapping 99→00.
  - `btn_set_sec`: seconds +1, wrapping 59→00. Minutes are unaffected.
  - Both set buttons in the same cycle: both increments apply.
  - `btn_start` with `cur`≠00:00: `preset`←`cur`, go to RUN. Set buttons in that cycle are ignored.
  - `btn_start` with `cur`=00:00: start is ignored; set buttons in that cycle apply.
- **RUN**
  - `tick`: decrement `cur` by one second, with BCD borrow (e.g. 10:00→09:59, 00:10→00:09).
  - If the decrement yields 00:00, go to DONE in the same edge with `blink`←1 and `acnt`←0.
  - `btn_start`: go to PAUSE. A coincident tick is discarded.
  - Set buttons are ignored.
- **PAUSE**
  - `btn_start`: go to RUN.
  - `tick` and set buttons are ignored.
  - `cur` is held.
- **DONE**
  - `alarm`=1.
  - Each `tick` toggles `blink` and increments `acnt`.
  - When the incremented `acnt` equals `ALARM_TICKS` (and `ALARM_TICKS`≠0): go to IDLE with `cur`←`preset`.
  - `btn_start`: go to IDLE with `cur`←`preset`.
- **Clear**
  - `btn_clear` in any state has highest priority.
  - It forces IDLE with `cur`←00:00 and `preset`←00:00, `alarm`←0, `blink`←1.
- **Enables**
  - Base enables are 1111.
  - In DONE with `blink`=0, all enables are 0.
  - Blanking (see Configuration) is applied on top of this.

## Timing
- All state changes happen on the `clk` edge that samples the input pulse. Outputs reflect the new state immediately after that edge, so latency is one cycle.
- Outputs are decoded from registers only and are glitch-free; there is no combinational path from inputs to outputs.
- Reset values:
  - state IDLE, `cur`=`preset`=00:00.
  - `digit_*`=0, `alarm`=0, `blink`=1, `acnt`=0.
  - `enable_3..0`=1111, or 0011 with the blanking macro defined.
- Reset mid-run or in DONE: the next cycle is IDLE at 00:00. `preset` is not retained.
- `tick` held high for several cycles is undefined; the bench must not do this.

## Configuration
- `LEADING_ZERO_BLANK_EN`
  - Defined:
    - `enable_3`=0 whenever `digit_3`=0.
    - `enable_2`=0 whenever both `digit_3` and `digit_2` are 0.
    - Seconds digits are never blanked.
    - Blanking is ANDed with the DONE blink.
  - Undefined: no blanking; enables come only from the blink logic.

## Test plan
- **Set:** reset, 3× `btn_set_min`, 61× `btn_set_sec` → digits 0,3,0,1. Wraps: 60 presses on 59 seconds gives 59, then 00. 100× `btn_set_min` from 00 returns to 00.
- **Run, borrow, expiry:** set 01:00 (`ALARM_TICKS`=3), start, 1 tick → 00:59. 59 more ticks → 00:00, state DONE, `alarm`=1, enables 1111. The next tick gives enables 0000. After the 3rd DONE tick → IDLE, digits 0,1,0,0, `alarm`=0.
- **Pause and coincidence:** RUN at 00:05; `btn_start` together with `tick` → PAUSE at 00:05. 4 ticks → still 00:05. `btn_start`, then 1 tick → 00:04.
- **Start at zero and clear:** `btn_start` at 00:00 → stays IDLE. At 02:30 in RUN, `btn_clear` together with `btn_start` → IDLE at 00:00, `alarm`=0.
- **Blanking (macro defined):** IDLE at 00:07 → enables 0011. At 05:00 → 0111. At 12:00 → 1111. With the macro undefined, 00:07 → 1111.
- **Reset mid-operation:** assert `rst` for one cycle in DONE → IDLE, 00:00, `alarm`=0 on the next cycle.

Source files
------------

// File: rtl/countdown_ctrl_if.sv
// countdown_ctrl_if: button/tick inputs and display digit/enable outputs
// of the mm:ss countdown sequencer, grouped for port connection.
interface countdown_ctrl_if;

    // Inputs to the controller
    logic       tick;
    logic       btn_start;
    logic       btn_set_min;
    logic       btn_set_sec;
    logic       btn_clear;

    // Digit values to the display scan module
    logic [3:0] digit_3;
    logic [3:0] digit_2;
    logic [3:0] digit_1;
    logic [3:0] digit_0;

    // Digit enables to the display scan module
    logic       enable_3;
    logic       enable_2;
    logic       enable_1;
    logic       enable_0;

    // Expiry indicator
    logic       alarm;

    // Source of the pulses: tick prescaler, debouncers, testbench
    modport master (
        output tick,
        output btn_start,
        output btn_set_min,
        output btn_set_sec,
        output btn_clear,
        input  digit_3,
        input  digit_2,
        input  digit_1,
        input  digit_0,
        input  enable_3,
        input  enable_2,
        input  enable_1,
        input  enable_0,
        input  alarm
    );

    // The countdown controller itself
    modport slave (
        input  tick,
        input  btn_start,
        input  btn_set_min,
        input  btn_set_sec,
        input  btn_clear,
        output digit_3,
        output digit_2,
        output digit_1,
        output digit_0,
        output enable_3,
        output enable_2,
        output enable_1,
        output enable_0,
        output alarm
    );

endinterface

// File: rtl/countdown_ctrl.sv
// countdown_ctrl: mm:ss BCD countdown sequencer (IDLE/RUN/PAUSE/DONE).
// Optional macro LEADING_ZERO_BLANK_EN blanks leading minute digits.
module countdown_ctrl #(
    parameter int unsigned ALARM_TICKS = 10
) (
    input  logic             clk,
    input  logic             rst,
    countdown_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [3:0] m_t;
        logic [3:0] m_o;
        logic [3:0] s_t;
        logic [3:0] s_o;
    } mmss_t;

    localparam logic [7:0] ALARM_LIM = 8'(ALARM_TICKS);
    localparam bit         ALARM_AUTO = (ALARM_TICKS != 0);

    // Minutes +1 in BCD, 99 wraps to 00; seconds untouched.
    function automatic mmss_t inc_min(input mmss_t v);
        mmss_t r;
        r = v;
        if (v.m_o == 4'd9) begin
            r.m_o = 4'd0;
            r.m_t = (v.m_t == 4'd9) ? 4'd0 : v.m_t + 4'd1;
        end else begin
            r.m_o = v.m_o + 4'd1;
        end
        return r;
    endfunction

    // Seconds +1 in BCD, 59 wraps to 00; minutes untouched.
    function automatic mmss_t inc_sec(input mmss_t v);
        mmss_t r;
        r = v;
        if (v.s_o == 4'd9) begin
            r.s_o = 4'd0;
            r.s_t = (v.s_t == 4'd5) ? 4'd0 : v.s_t + 4'd1;
        end else begin
            r.s_o = v.s_o + 4'd1;
        end
        return r;
    endfunction

    // One-second decrement with BCD borrow through all four digits.
    // Saturates at 00:00 so a stray zero value can never underflow.
    function automatic mmss_t dec_one(input mmss_t v);
        mmss_t r;
        r = v;
        if (v == '0) begin
            r = '0;
        end else if (v.s_o != 4'd0) begin
            r.s_o = v.s_o - 4'd1;
        end else if (v.s_t != 4'd0) begin
            r.s_o = 4'd9;
            r.s_t = v.s_t - 4'd1;
        end else if (v.m_o != 4'd0) begin
            r.s_o = 4'd9;
            r.s_t = 4'd5;
            r.m_o = v.m_o - 4'd1;
        end else begin
            r.s_o = 4'd9;
            r.s_t = 4'd5;
            r.m_o = 4'd9;
            r.m_t = v.m_t - 4'd1;
        end
        return r;
    endfunction

    state_t     r_state;
    mmss_t      r_cur;
    mmss_t      r_preset;
    logic       r_blink;
    logic [7:0] r_acnt;

    state_t     w_state;
    mmss_t      w_cur;
    mmss_t      w_preset;
    logic       w_blink;
    logic [7:0] w_acnt;

    mmss_t      w_set_val;
    mmss_t      w_dec_val;
    logic       w_cur_zero;
    logic [7:0] w_acnt_inc;
    logic       w_alarm;
    logic       w_dark;
    logic [3:0] w_base_en;
    logic [3:0] w_en;

    assign w_cur_zero = (r_cur == '0);
    assign w_dec_val  = dec_one(r_cur);
    assign w_acnt_inc = r_acnt + 8'd1;

    // Value after any set buttons pressed this cycle (both may apply).
    always_comb begin
        w_set_val = r_cur;
        if (bus.btn_set_min) begin
            w_set_val = inc_min(w_set_val);
        end
        if (bus.btn_set_sec) begin
            w_set_val = inc_sec(w_set_val);
        end
    end

    // State, count, preset, blink and DONE-tick counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cur    <= '0;
            r_preset <= '0;
            r_blink  <= 1'b1;
            r_acnt   <= 8'd0;
        end else begin
            r_state  <= w_state;
            r_cur    <= w_cur;
            r_preset <= w_preset;
            r_blink  <= w_blink;
            r_acnt   <= w_acnt;
        end
    end

    // Next-state logic; clear overrides every state.
    always_comb begin
        w_state  = r_state;
        w_cur    = r_cur;
        w_preset = r_preset;
        w_blink  = r_blink;
        w_acnt   = r_acnt;
        if (bus.btn_clear) begin
            w_state  = S_IDLE;
            w_cur    = '0;
            w_preset = '0;
            w_blink  = 1'b1;
            w_acnt   = 8'd0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.btn_start && !w_cur_zero) begin
                        w_preset = r_cur;
                        w_state  = S_RUN;
                    end else begin
                        w_cur = w_set_val;
                    end
                end
                S_RUN: begin
                    if (bus.btn_start) begin
                        w_state = S_PAUSE;
                    end else if (bus.tick) begin
                        w_cur = w_dec_val;
                        if (w_dec_val == '0) begin
                            w_state = S_DONE;
                            w_blink = 1'b1;
                            w_acnt  = 8'd0;
                        end
                    end
                end
                S_PAUSE: begin
                    if (bus.btn_start) begin
                        w_state = S_RUN;
                    end
                end
                S_DONE: begin
                    if (bus.btn_start) begin
                        w_state = S_IDLE;
                        w_cur   = r_preset;
                        w_blink = 1'b1;
                        w_acnt  = 8'd0;
                    end else if (bus.tick) begin
                        w_blink = ~r_blink;
                        w_acnt  = w_acnt_inc;
                        if (ALARM_AUTO && w_acnt_inc == ALARM_LIM) begin
                            w_state = S_IDLE;
                            w_cur   = r_preset;
                            w_blink = 1'b1;
                            w_acnt  = 8'd0;
                        end
                    end
                end
                default: begin
                    w_state = S_IDLE;
                end
            endcase
        end
    end

    // Register-only output decode: blink dims all digits in DONE.
    always_comb begin
        w_alarm   = (r_state == S_DONE);
        w_dark    = w_alarm && !r_blink;
        w_base_en = {4{~w_dark}};
`ifdef LEADING_ZERO_BLANK_EN
        w_en = w_base_en & {
            (r_cur.m_t != 4'd0),
            (r_cur.m_t != 4'd0) || (r_cur.m_o != 4'd0),
            2'b11
        };
`else
        w_en = w_base_en;
`endif
    end

    assign bus.digit_3  = r_cur.m_t;
    assign bus.digit_2  = r_cur.m_o;
    assign bus.digit_1  = r_cur.s_t;
    assign bus.digit_0  = r_cur.s_o;
    assign bus.enable_3 = w_en[3];
    assign bus.enable_2 = w_en[2];
    assign bus.enable_1 = w_en[1];
    assign bus.enable_0 = w_en[0];
    assign bus.alarm    = w_alarm;

endmodule

// File: tb/tb_countdown_ctrl.sv
// tb_countdown_ctrl: scenario tasks with a scoreboard of expected
// {alarm, enables, digits}; honours LEADING_ZERO_BLANK_EN if defined.
module tb_countdown_ctrl;

    localparam logic [5:0] K_RST   = 6'b100000;
    localparam logic [5:0] K_TICK  = 6'b010000;
    localparam logic [5:0] K_START = 6'b001000;
    localparam logic [5:0] K_MIN   = 6'b000100;
    localparam logic [5:0] K_SEC   = 6'b000010;
    localparam logic [5:0] K_CLR   = 6'b000001;

    typedef struct {
        logic [5:0]  stim;
        bit          chk;
        string       tag;
        logic [20:0] v;
    } step_t;

    typedef struct {
        string       tag;
        logic [20:0] v;
    } exp_t;

    logic clk;
    logic rst;
    logic [20:0] w_obs;

    step_t plan[$];
    exp_t  sb[$];
    int    n_vec;
    int    n_bad;

    countdown_ctrl_if bus();

    countdown_ctrl #(.ALARM_TICKS(3)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign w_obs = {bus.alarm,
                    bus.enable_3, bus.enable_2,
                    bus.enable_1, bus.enable_0,
                    bus.digit_3, bus.digit_2,
                    bus.digit_1, bus.digit_0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Total seconds -> mm:ss BCD by arithmetic.
    function automatic logic [15:0] bcd(input int secs);
        int m;
        int s;
        m = secs / 60;
        s = secs % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic [3:0] exp_en(input logic [15:0] d, input bit dark);
        logic [3:0] e;
        e = dark ? 4'b0000 : 4'b1111;
`ifdef LEADING_ZERO_BLANK_EN
        if (d[15:12] == 4'd0) e[3] = 1'b0;
        if (d[15:8] == 8'd0) e[2] = 1'b0;
`endif
        return e;
    endfunction

    function automatic logic [20:0] mk(input logic [15:0] d, input bit dark, input bit al);
        return {al, exp_en(d, dark), d};
    endfunction

    function automatic void add(input logic [5:0] s, input bit c, input string t, input logic [20:0] v);
        step_t p;
        p.stim = s;
        p.chk  = c;
        p.tag  = t;
        p.v    = v;
        plan.push_back(p);
    endfunction

    task automatic apply(input logic [5:0] s);
        @(negedge clk);
        rst             = s[5];
        bus.tick        = s[4];
        bus.btn_start   = s[3];
        bus.btn_set_min = s[2];
        bus.btn_set_sec = s[1];
        bus.btn_clear   = s[0];
        @(posedge clk);
        #1;
        rst             = 1'b0;
        bus.tick        = 1'b0;
        bus.btn_start   = 1'b0;
        bus.btn_set_min = 1'b0;
        bus.btn_set_sec = 1'b0;
        bus.btn_clear   = 1'b0;
    endtask

    task automatic test_reset();
        step_t p;
        exp_t  e;
        add(K_RST, 1, "reset", mk(16'h0000, 0, 0));
        add(6'b0, 1, "reset_idle", mk(16'h0000, 0, 0));
        while (plan.size() > 0) begin
            p = plan.pop_front();
            if (p.chk) sb.push_back('{tag: p.tag, v: p.v});
            apply(p.stim);
            if (p.chk) begin
                e = sb.pop_front();
                n_vec++;
                if (w_obs !== e.v) begin
                    n_bad++;
                    $display("FAIL %s: got %h want %h", e.tag, w_obs, e.v);
                end
            end
        end
    endtask

    task automatic test_set();
        step_t p;
        exp_t  e;
        add(K_RST, 0, "", '0);
        for (int i = 0; i < 3; i++)
            add(K_MIN, 1, "set_min", mk(bcd((i + 1) * 60), 0, 0));
        for (int i = 0; i < 61; i++)
            add(K_SEC, 1, "set_sec_wrap", mk(bcd(180 + (i + 1) % 60), 0, 0));
        add(K_MIN | K_SEC, 1, "set_both", mk(bcd(242), 0, 0));
        add(K_RST, 0, "", '0);
        for (int i = 0; i < 100; i++)
            add(K_MIN, 1, "set_min_wrap", mk(bcd(((i + 1) % 100) * 60), 0, 0));
        while (plan.size() > 0) begin
            p = plan.pop_front();
            if (p.chk) sb.push_back('{tag: p.tag, v: p.v});
            apply(p.stim);
            if (p.chk) begin
                e = sb.pop_front();
                n_vec++;
                if (w_obs !== e.v) begin
                    n_bad++;
                    $display("FAIL %s: got %h want %h", e.tag, w_obs, e.v);
                end
            end
        end
    endtask

    task automatic test_run_expiry();
        step_t p;
        exp_t  e;
        add(K_RST, 0, "", '0);
        add(K_MIN, 0, "", '0);
        add(K_START, 1, "run_start", mk(bcd(60), 0, 0));
        add(K_TICK, 1, "run_borrow", mk(bcd(59), 0, 0));
        add(K_MIN | K_SEC, 1, "run_set_ignored", mk(bcd(59), 0, 0));
        for (int i = 1; i < 59; i++)
            add(K_TICK, 1, "run_tick", mk(bcd(59 - i), 0, 0));
        add(K_TICK, 1, "done_enter", mk(16'h0000, 0, 1));
        add(6'b0, 1, "done_hold", mk(16'h0000, 0, 1));
        add(K_TICK, 1, "done_blink_off", mk(16'h0000, 1, 1));
        add(K_TICK, 1, "done_blink_on", mk(16'h0000, 0, 1));
        add(K_TICK, 1, "done_timeout", mk(bcd(60), 0, 0));
        while (plan.size() > 0) begin
            p = plan.pop_front();
            if (p.chk) sb.push_back('{tag: p.tag, v: p.v});
            apply(p.stim);
            if (p.chk) begin
                e = sb.pop_front();
                n_vec++;
                if (w_obs !== e.v) begin
                    n_bad++;
                    $display("FAIL %s: got %h want %h", e.tag, w_obs, e.v);
                end
            end
        end
    endtask

    task automatic test_pause();
        step_t p;
        exp_t  e;
        add(K_RST, 0, "", '0);
        for (int i = 0; i < 5; i++) add(K_SEC, 0, "", '0);
        add(K_START, 1, "pause_run", mk(bcd(5), 0, 0));
        add(K_START | K_TICK, 1, "pause_coinc", mk(bcd(5), 0, 0));
        for (int i = 0; i < 4; i++)
            add(K_TICK, 1, "pause_tick", mk(bcd(5), 0, 0));
        add(K_MIN | K_SEC, 1, "pause_set", mk(bcd(5), 0, 0));
        add(K_START, 1, "pause_resume", mk(bcd(5), 0, 0));
        add(K_TICK, 1, "resume_tick", mk(bcd(4), 0, 0));
        while (plan.size() > 0) begin
            p = plan.pop_front();
            if (p.chk) sb.push_back('{tag: p.tag, v: p.v});
            apply(p.stim);
            if (p.chk) begin
                e = sb.pop_front();
                n_vec++;
                if (w_obs !== e.v) begin
                    n_bad++;
                    $display("FAIL %s: got %h want %h", e.tag, w_obs, e.v);
                end
            end
        end
    endtask

    task automatic test_zero_clear();
        step_t p;
        exp_t  e;
        add(K_RST, 0, "", '0);
        add(K_START, 1, "start_zero", mk(16'h0000, 0, 0));
        add(K_TICK, 1, "start_zero_tick", mk(16'h0000, 0, 0));
        add(K_START | K_SEC, 1, "start_zero_set", mk(bcd(1), 0, 0));
        add(K_RST, 0, "", '0);
        add(K_MIN, 0, "", '0);
        add(K_MIN, 0, "", '0);
        for (int i = 0; i < 30; i++) add(K_SEC, 0, "", '0);
        add(K_START, 1, "run_0230", mk(bcd(150), 0, 0));
        add(K_CLR | K_START, 1, "clear_run", mk(16'h0000, 0, 0));
        add(K_TICK, 1, "clear_idle", mk(16'h0000, 0, 0));
        add(K_START, 1, "clear_no_start", mk(16'h0000, 0, 0));
        add(K_SEC, 0, "", '0);
        add(K_SEC, 0, "", '0);
        add(K_START, 1, "ack_start", mk(bcd(2), 0, 0));
        add(K_TICK, 1, "ack_tick", mk(bcd(1), 0, 0));
        add(K_TICK, 1, "ack_done", mk(16'h0000, 0, 1));
        add(K_START, 1, "done_ack", mk(bcd(2), 0, 0));
        add(K_START, 0, "", '0);
        add(K_TICK, 0, "", '0);
        add(K_TICK, 1, "done_again", mk(16'h0000, 0, 1));
        add(K_TICK, 1, "done_dark", mk(16'h0000, 1, 1));
        add(K_CLR, 1, "clear_done", mk(16'h0000, 0, 0));
        add(K_START, 1, "preset_cleared", mk(16'h0000, 0, 0));
        while (plan.size() > 0) begin
            p = plan.pop_front();
            if (p.chk) sb.push_back('{tag: p.tag, v: p.v});
            apply(p.stim);
            if (p.chk) begin
                e = sb.pop_front();
                n_vec++;
                if (w_obs !== e.v) begin
                    n_bad++;
                    $display("FAIL %s: got %h want %h", e.tag, w_obs, e.v);
                end
            end
        end
    endtask

    task automatic test_blank();
        step_t p;
        exp_t  e;
        add(K_RST, 0, "", '0);
        for (int i = 0; i < 7; i++)
            add(K_SEC, 1, "blank_secs", mk(bcd(i + 1), 0, 0));
        add(K_RST, 0, "", '0);
        for (int i = 0; i < 12; i++)
            add(K_MIN, 1, "blank_mins", mk(bcd((i + 1) * 60), 0, 0));
        while (plan.size() > 0) begin
            p = plan.pop_front();
            if (p.chk) sb.push_back('{tag: p.tag, v: p.v});
            apply(p.stim);
            if (p.chk) begin
                e = sb.pop_front();
                n_vec++;
                if (w_obs !== e.v) begin
                    n_bad++;
                    $display("FAIL %s: got %h want %h", e.tag, w_obs, e.v);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        step_t p;
        exp_t  e;
        add(K_RST, 0, "", '0);
        add(K_SEC, 0, "", '0);
        add(K_START, 0, "", '0);
        add(K_TICK, 1, "mid_done", mk(16'h0000, 0, 1));
        add(K_TICK, 1, "mid_dark", mk(16'h0000, 1, 1));
        add(K_RST, 1, "reset_mid", mk(16'h0000, 0, 0));
        add(K_START, 1, "preset_lost", mk(16'h0000, 0, 0));
        while (plan.size() > 0) begin
            p = plan.pop_front();
            if (p.chk) sb.push_back('{tag: p.tag, v: p.v});
            apply(p.stim);
            if (p.chk) begin
                e = sb.pop_front();
                n_vec++;
                if (w_obs !== e.v) begin
                    n_bad++;
                    $display("FAIL %s: got %h want %h", e.tag, w_obs, e.v);
                end
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec           = 0;
        n_bad           = 0;
        rst             = 1'b1;
        bus.tick        = 1'b0;
        bus.btn_start   = 1'b0;
        bus.btn_set_min = 1'b0;
        bus.btn_set_sec = 1'b0;
        bus.btn_clear   = 1'b0;
        test_reset();
        test_set();
        test_run_expiry();
        test_pause();
        test_zero_clear();
        test_blank();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
